pdn_out_seq: RTL

- Sequencer for the PuDianNao output selector stage, which multiplexes counter, adder, multiplier, acc, nonlin and k-sorted results onto one scalar port and one 16-lane vector port.
- Accepts one drain command per operation and waits for the matching functional-unit done strobe.
- Drives the selector's sel/count so the selector's registered outputs are valid, then presents them beat by beat to the output buffer over a valid/ready handshake.
- A k-sort result (values plus indices, 2K words) takes ceil(2K/16) beats.

---
 rtl/pdn_out_seq_pkg.sv | 40 ++++
 rtl/pdn_out_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pdn_out_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : pdn_pkg
//  Purpose : Shared definitions for the PuDianNao output selector path:
//            selector op codes, vector lane count and a beat-count helper
//            that the sequencer and the selector both use.
//  Revision: 1.0 - initial release
// ============================================================================
package pdn_pkg;

    // Selector codes. SEL_NONE makes the selector hold its outputs.
    typedef enum logic [2:0] {
        SEL_NONE   = 3'd0,
        SEL_CNT    = 3'd1,
        SEL_ADD    = 3'd2,
        SEL_MUL    = 3'd3,
        SEL_ACC    = 3'd4,
        SEL_NONLIN = 3'd5,
        SEL_KSORT  = 3'd6
    } sel_op_e;

    // Vector port width in 32-bit words.
    localparam int LANES = 16;

    // Number of output beats one drain of 'op' takes. A k-sort result is
    // 2*k words (values plus indices) spread over 'lanes'-wide beats; every
    // other legal op is a single beat. Illegal codes take no beats.
    function automatic int beats_for(input logic [2:0] op, input int k,
                                     input int lanes);
        if (op == SEL_KSORT) begin
            beats_for = (2 * k + lanes - 1) / lanes;
        end else if (op >= SEL_CNT && op <= SEL_NONLIN) begin
            beats_for = 1;
        end else begin
            beats_for = 0;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/pdn_out_seq.sv
`default_nettype none
// ============================================================================
//  Module  : pdn_out_seq
//  Purpose : Output sequencer for the PuDianNao selector stage. Accepts one
//            drain command, waits for the matching unit done strobe, drives
//            sel/count so the selector's registered outputs settle, then
//            hands each beat to the output buffer over valid/ready.
//  Ports   : clk, rst (async, active-low)
//            cmd_valid_i / cmd_ready_o / cmd_op_i  - drain command
//            unit_done_i                             - one-hot unit done
//            sel_o / count_o                         - selector control
//            out_valid_o / out_ready_i               - beat handshake
//            out_is_vector_o / out_lanes_o / out_last_o - beat attributes
//            busy_o, err_illegal_o                   - status
//  Revision: 1.0 - initial release
// ============================================================================
module pdn_out_seq
    import pdn_pkg::*;
#(
    parameter int K     = 20,
    parameter int LANES = pdn_pkg::LANES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [2:0]  cmd_op_i,
    input  logic [5:0]  unit_done_i,
    output logic [2:0]  sel_o,
    output logic [31:0] count_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        out_is_vector_o,
    output logic [4:0]  out_lanes_o,
    output logic        out_last_o,
    output logic        busy_o,
    output logic        err_illegal_o
);

    localparam int BEATS_KS = (2 * K + LANES - 1) / LANES;
    localparam int BW       = (BEATS_KS > 1) ? $clog2(BEATS_KS) : 1;

    localparam logic [4:0] FULL_LANES = 5'(LANES);
    localparam logic [4:0] LAST_LANES = 5'(2 * K - LANES * (BEATS_KS - 1));

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_SETTLE  = 3'd3;
    localparam logic [2:0] S_PRESENT = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [2:0]    sel_q, sel_d;
    logic [31:0]   count_q, count_d;
    logic          valid_q, valid_d;
    logic          vec_q, vec_d;
    logic [4:0]    lanes_q, lanes_d;
    logic          last_q, last_d;
    logic          busy_q, busy_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;

    logic [2:0]    w_op_idx;
    logic [5:0]    w_done_mask;
    logic          w_done_hit;
    logic          w_last;
    logic          w_is_vec;
    logic [4:0]    w_lanes;

    // Only the done bit of the captured op may advance the FSM.
    assign w_op_idx    = op_q - 3'd1;
    assign w_done_mask = 6'd1 << w_op_idx;
    assign w_done_hit  = |(unit_done_i & w_done_mask);

    assign w_last = (32'(beat_q) == 32'(beats_for(op_q, K, LANES) - 1));

    always_comb begin
        w_is_vec = 1'b0;
        w_lanes  = 5'd0;
        case (op_q)
            SEL_CNT, SEL_ADD, SEL_MUL: begin
                w_is_vec = 1'b1;
                w_lanes  = FULL_LANES;
            end
            SEL_ACC, SEL_NONLIN: begin
                w_is_vec = 1'b0;
                w_lanes  = 5'd1;
            end
            SEL_KSORT: begin
                w_is_vec = 1'b1;
                // Only the final k-sort beat can be partially filled.
                w_lanes  = w_last ? LAST_LANES : FULL_LANES;
            end
            default: begin
                w_is_vec = 1'b0;
                w_lanes  = 5'd0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        beat_d  = beat_q;
        sel_d   = sel_q;
        count_d = count_q;
        valid_d = valid_q;
        vec_d   = vec_q;
        lanes_d = lanes_q;
        last_d  = last_q;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    beat_d = '0;
                    if (cmd_op_i == SEL_NONE || cmd_op_i == 3'd7) begin
                        err_d = 1'b1;
                    end else begin
                        op_d    = cmd_op_i;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (w_done_hit) begin
                    // sel/count become visible in ISSUE so the selector
                    // samples them on the following edge.
                    sel_d   = op_q;
                    count_d = 32'(beat_q);
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                valid_d = 1'b1;
                vec_d   = w_is_vec;
                lanes_d = w_lanes;
                last_d  = w_last;
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                if (out_ready_i) begin
                    valid_d = 1'b0;
                    vec_d   = 1'b0;
                    lanes_d = 5'd0;
                    last_d  = 1'b0;
                    if (w_last) begin
                        sel_d   = SEL_NONE;
                        count_d = 32'd0;
                        state_d = S_IDLE;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        count_d = 32'(beat_q + 1'b1);
                        state_d = S_ISSUE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered copies of the next state.
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            op_q    <= 3'd0;
            beat_q  <= '0;
            sel_q   <= 3'd0;
            count_q <= 32'd0;
            valid_q <= 1'b0;
            vec_q   <= 1'b0;
            lanes_q <= 5'd0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            beat_q  <= beat_d;
            sel_q   <= sel_d;
            count_q <= count_d;
            valid_q <= valid_d;
            vec_q   <= vec_d;
            lanes_q <= lanes_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready_o     = ready_q;
    assign sel_o           = sel_q;
    assign count_o         = count_q;
    assign out_valid_o     = valid_q;
    assign out_is_vector_o = vec_q;
    assign out_lanes_o     = lanes_q;
    assign out_last_o      = last_q;
    assign busy_o          = busy_q;
    assign err_illegal_o   = err_q;

endmodule
`default_nettype wire
